mpu_store_serializer: RTL
=========================

Name: mpu_store_serializer

Overview:
Store-side counterpart of the MPU matrix load path. On a STORE request it reads one matrix, with its dimensions, from the matrix register file. It then streams the elements out one FP word per handshake, in row-major order, with row/col tags and a last flag. The block sits between the matrix register file and the MPU result/output bus.

Parameters:
FP, 32, floating-point element width (global_defs::FP)
M, 5, max matrix rows
N, 5, max matrix columns (row stride of register-file matrix port)
MATRIX_REGISTERS, 16, register file depth
MBITS, $clog2(M)-1, row index MSB
NBITS, $clog2(N)-1, col index MSB
MATRIX_REG_BITS, $clog2(MATRIX_REGISTERS)-1, address MSB

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
store_req  in  1  start request; sampled only in STORE_IDLE
store_addr  in  MATRIX_REG_BITS+1  matrix register to store
store_busy  out  1  high in any state other than STORE_IDLE
reg_rd_en  out  1  register-file read strobe
reg_rd_addr  out  MATRIX_REG_BITS+1  register-file read address
reg_rd_matrix  in  M*N*FP  packed [0:M*N-1][FP-1:0]; element r*N+c at index r*N+c (index 0 = MSB slice); valid cycle after reg_rd_en
reg_rd_m  in  4  stored row count, same timing as reg_rd_matrix
reg_rd_n  in  4  stored column count, same timing
elem_valid  out  1  element on elem_data is valid
elem_ready  in  1  consumer accepts element
elem_data  out  FP  element value
elem_row  out  MBITS+1  row index of elem_data
elem_col  out  NBITS+1  column index of elem_data
elem_last  out  1  high with final element (row m-1, col n-1)
store_done  out  1  one-cycle pulse after last handshake
store_err  out  1  one-cycle pulse on illegal dimensions

Behaviour:
- Reset (rst=0, async): state STORE_IDLE, counters 0, buffer cleared. All outputs are 0.
- reg_rd_en = (state==STORE_IDLE && store_req); reg_rd_addr = store_addr. Both are combinational. reg_rd_addr = 0 when idle without a request.
- STORE_IDLE: when store_req=1, go to STORE_FETCH.
- STORE_FETCH: capture reg_rd_matrix, reg_rd_m and reg_rd_n into a local buffer.
  - Illegal dims (m==0, n==0, m>M or n>N): go to STORE_IDLE and pulse store_err the next cycle. Nothing is streamed.
  - Otherwise: go to STORE_STREAM with row=0, col=0.
- STORE_STREAM: elem_valid=1. elem_data = buffer[row*N+col]; elem_row/elem_col = counters.
  - elem_last = (row==m-1 && col==n-1).
  - A transfer occurs when elem_valid && elem_ready.
  - On transfer: col++. If col==n-1, col=0 and row++.
  - On transfer with elem_last: go to STORE_DONE.
- While elem_ready=0: valid, data, row, col and last hold stable. Valid never drops before the handshake.
- STORE_DONE: store_done=1 for one cycle, then STORE_IDLE. store_busy=1.
- Latency: req in cycle 0 → rd_en cycle 0 → first elem_valid cycle 2.
  - With ready held high: one element per cycle; m×n elements occupy cycles 2..m*n+1; store_done in cycle m*n+2.
  - Earliest next accepted req is cycle m*n+3.
- store_req while busy is ignored; no queuing.
- Buffer snapshot: later register-file writes to the same address do not affect an in-progress stream.
- Reset mid-stream aborts immediately. No store_done or store_err follows; the stream is truncated.
- Element values are passed through bit-exactly; no FP arithmetic.

Decomposition:
- In mpu_pkg: add store_ser_state_t, 2-bit, {STORE_IDLE, STORE_FETCH, STORE_STREAM, STORE_DONE}. It is kept distinct from the existing 1-bit store_state_t.
- In mpu_pkg: add an element-beat struct {data, row, col, last}.
- M, N and FP come from global_defs.
- Natural sub-module: mpu_rc_counter. It is a row/col counter with load-dims, advance, wrap and last outputs, reusable by the load-side deserializer.

Test Plan:
- 3x3 at addr 2, elements 1.0..9.0 (0x3F800000..0x41100000), ready=1:
  - valid in cycles 2..10; (row,col) sequence (0,0)..(2,2); last only on 9.0.
  - done in cycle 11.
- Same 3x3, ready toggled 1,0,0,1,…: every element appears exactly once, in order. Data/row/col are stable across stalls; last and done are correct.
- 1x1 (m=n=1): single beat with last=1 in cycle 2; done in cycle 3.
- 5x5 max (stride N=5): 25 beats. Element (4,4) is taken from index 24; last on 25th beat.
- m=0, then n=6: no elem_valid; store_err pulses once in cycle 2; busy drops by cycle 2.
- Second req asserted mid-stream → ignored, reg_rd_en stays 0. Assert rst low after 4th beat → all outputs 0 asynchronously, no done; a new req afterwards streams correctly.

Source files
------------

// File: rtl/mpu_store_serializer_pkg.sv
// Shared MPU constants and types used by the store serializer and its
// row/column counter.
package global_defs;
  localparam int FP = 32;
  localparam int M  = 5;
  localparam int N  = 5;
endpackage

package mpu_pkg;
  import global_defs::*;

  localparam int MATRIX_REGISTERS = 16;
  localparam int MBITS            = $clog2(M) - 1;
  localparam int NBITS            = $clog2(N) - 1;
  localparam int MATRIX_REG_BITS  = $clog2(MATRIX_REGISTERS) - 1;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } store_state_t;

  typedef enum logic [1:0] {
    STORE_IDLE   = 2'd0,
    STORE_FETCH  = 2'd1,
    STORE_STREAM = 2'd2,
    STORE_DONE   = 2'd3
  } store_ser_state_t;

  typedef struct packed {
    logic [FP-1:0]  data;
    logic [MBITS:0] row;
    logic [NBITS:0] col;
    logic           last;
  } elem_beat_t;

  function automatic logic dims_illegal(input logic [3:0] m, input logic [3:0] n);
    return (m == 4'd0) || (n == 4'd0) || (m > 4'(M)) || (n > 4'(N));
  endfunction
endpackage

// File: rtl/mpu_store_serializer_rc_counter.sv
// Row-major row/column walker over an m x n matrix; load latches the
// dimensions and restarts at (0,0), advance steps one element.
module mpu_rc_counter
  import mpu_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [3:0]     m_i,
  input  logic [3:0]     n_i,
  input  logic           advance_i,
  output logic [MBITS:0] row_o,
  output logic [NBITS:0] col_o,
  output logic           last_o
);
  localparam int ROW_W = MBITS + 1;
  localparam int COL_W = NBITS + 1;

  logic [MBITS:0] row_q, m_last_q;
  logic [NBITS:0] col_q, n_last_q;
  logic           col_wrap_s;

  assign col_wrap_s = (col_q == n_last_q);

  // Counter and dimension-limit registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q    <= '0;
      col_q    <= '0;
      m_last_q <= '0;
      n_last_q <= '0;
    end else if (load_i) begin
      row_q    <= '0;
      col_q    <= '0;
      m_last_q <= ROW_W'(m_i - 4'd1);
      n_last_q <= COL_W'(n_i - 4'd1);
    end else if (advance_i) begin
      if (col_wrap_s) begin
        col_q <= '0;
        row_q <= (row_q == m_last_q) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == m_last_q) && col_wrap_s;
endmodule

// File: rtl/mpu_store_serializer.sv
// Reads one matrix from the register file on a store request and streams
// it element by element in row-major order over a valid/ready port.
module mpu_store_serializer
  import global_defs::*;
  import mpu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     store_req_i,
  input  logic [MATRIX_REG_BITS:0] store_addr_i,
  output logic                     store_busy_o,
  output logic                     reg_rd_en_o,
  output logic [MATRIX_REG_BITS:0] reg_rd_addr_o,
  input  logic [M*N*FP-1:0]        reg_rd_matrix_i,
  input  logic [3:0]               reg_rd_m_i,
  input  logic [3:0]               reg_rd_n_i,
  output logic                     elem_valid_o,
  input  logic                     elem_ready_i,
  output logic [FP-1:0]            elem_data_o,
  output logic [MBITS:0]           elem_row_o,
  output logic [NBITS:0]           elem_col_o,
  output logic                     elem_last_o,
  output logic                     store_done_o,
  output logic                     store_err_o
);
  localparam int IDX_W = $clog2(M * N);

  store_ser_state_t state_q;
  logic             busy_q, valid_q, done_q, err_q;
  logic [FP-1:0]    buf_q [M*N];
  logic [MBITS:0]   row_s;
  logic [NBITS:0]   col_s;
  logic             last_s, xfer_s, rd_en_s, illegal_s;
  logic [IDX_W-1:0] idx_s;
  elem_beat_t       beat_s;

  assign rd_en_s   = (state_q == STORE_IDLE) && store_req_i;
  assign xfer_s    = valid_q && elem_ready_i;
  assign illegal_s = dims_illegal(reg_rd_m_i, reg_rd_n_i);

  mpu_rc_counter u_rc_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (state_q == STORE_FETCH),
    .m_i       (reg_rd_m_i),
    .n_i       (reg_rd_n_i),
    .advance_i (xfer_s),
    .row_o     (row_s),
    .col_o     (col_s),
    .last_o    (last_s)
  );

  // Control FSM; status outputs are flops updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STORE_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        STORE_IDLE: begin
          if (store_req_i) begin
            state_q <= STORE_FETCH;
            busy_q  <= 1'b1;
          end
        end
        STORE_FETCH: begin
          if (illegal_s) begin
            state_q <= STORE_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q <= STORE_STREAM;
            valid_q <= 1'b1;
          end
        end
        STORE_STREAM: begin
          if (xfer_s && last_s) begin
            state_q <= STORE_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        STORE_DONE: begin
          state_q <= STORE_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= STORE_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot of the fetched matrix so later register-file writes cannot
  // disturb an in-progress stream. Slice 0 of the packed port is the MSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < M * N; k++) buf_q[k] <= '0;
    end else if (state_q == STORE_FETCH) begin
      for (int k = 0; k < M * N; k++) buf_q[k] <= reg_rd_matrix_i[(M*N-1-k)*FP +: FP];
    end
  end

  assign idx_s = IDX_W'(row_s) * IDX_W'(N) + IDX_W'(col_s);

  // Beat presented on the element port; forced to zero outside streaming.
  always_comb begin
    beat_s = '0;
    if (valid_q) begin
      beat_s.data = buf_q[idx_s];
      beat_s.row  = row_s;
      beat_s.col  = col_s;
      beat_s.last = last_s;
    end else begin
      beat_s = '0;
    end
  end

  assign reg_rd_en_o   = rd_en_s;
  assign reg_rd_addr_o = rd_en_s ? store_addr_i : '0;
  assign store_busy_o  = busy_q;
  assign elem_valid_o  = valid_q;
  assign elem_data_o   = beat_s.data;
  assign elem_row_o    = beat_s.row;
  assign elem_col_o    = beat_s.col;
  assign elem_last_o   = beat_s.last;
  assign store_done_o  = done_q;
  assign store_err_o   = err_q;
endmodule
